crc7_h45_frame_checker: RTL and testbench
=========================================

# crc7_h45_frame_checker

Serial CRC7 frame receiver and checker for x^7+x^3+1 protected command frames, the receive-side counterpart of the serial CRC7 generator. It sits on the command line input. It does the following:
- hunts for a start bit;
- deserializes a fixed-length payload MSB first while accumulating CRC7 over it;
- captures the 7 transmitted CRC bits and the end bit;
- reports the payload with CRC and framing status as a single-cycle result strobe.

## Interface
- RST_SEED_VAL, 7'h00, CRC accumulator seed loaded at start-bit detection, reset and clear
- PAYLOAD_BITS, 40, bits covered by CRC, start bit included; legal range 8..64
- TIMEOUT_CYCLES, 256, idle-cycle limit; used only with CRC7_CHK_TIMEOUT_EN
- CLK  in  1  clock; all logic rises on posedge CLK
- RST  in  1  reset; **asynchronous, active-high**
- clear  in  1  synchronous abort to IDLE, priority over enable
- enable  in  1  bit strobe; `in` is consumed only on cycles with enable=1
- in  in  1  serial data, MSB first; line idles high
- busy  out  1  high while in any state other than IDLE
- frame_valid  out  1  one-cycle result strobe
- frame_data  out  PAYLOAD_BITS  received payload, start bit in MSB, held until next frame_valid
- rx_crc  out  7  received CRC field, held with frame_data
- crc_err  out  1  rx_crc != computed CRC; valid with frame_valid, held
- end_err  out  1  end bit was 0; valid with frame_valid, held
- timeout_err  out  1  one-cycle abort strobe; constant 0 without CRC7_CHK_TIMEOUT_EN

## Operation
- CRC step on each consumed bit, register c[6:0]:
  - fb = in ^ c[6];
  - next = {c[5], c[4], c[3], c[2]^fb, c[1], c[0], fb}.
- States:
  - IDLE: the first enable cycle with in=0 seeds c with RST_SEED_VAL, applies one CRC step for the start bit, shifts it in, sets bit counter to 1, and moves to PAYLOAD. Enable with in=1 is ignored.
  - PAYLOAD: each enable applies a CRC step and shifts into the data register. The bit after count reaches PAYLOAD_BITS moves the block to CRC.
  - CRC: 7 enabled bits shift into the rx_crc register, MSB first, with no CRC update. After the 7th bit, the block moves to END.
  - END: the next enabled bit is the end bit. On that edge:
    - load outputs frame_data, rx_crc, crc_err, end_err;
    - pulse frame_valid;
    - return to IDLE.
- frame_valid fires regardless of error status; the error flags qualify it.
- Non-enable cycles hold all state, counters and CRC.
- clear or RST: state=IDLE, counter=0, c=RST_SEED_VAL, no frame_valid. Held outputs keep their values on clear and zero on RST.
- A reset or clear mid-frame discards the partial frame.

## Timing
- Reset values: busy=0, frame_valid=0, frame_data=0, rx_crc=0, crc_err=0, end_err=0, timeout_err=0.
- Latency: frame_valid is high in the cycle after the enabled cycle that carries the end bit. The minimum is PAYLOAD_BITS+8 enabled cycles from start bit to strobe.
- Back-to-back frames: a start bit on the enable cycle right after the end bit is accepted. Since the block is in IDLE during the frame_valid cycle, that cycle may itself carry the next start bit.
- If clear and enable arrive together, clear wins and the bit is dropped.
- busy rises the cycle after start-bit acceptance and falls together with frame_valid.

## Configuration
- CRC7_CHK_TIMEOUT_EN defined:
  - A counter resets on every enable and increments on each non-enable cycle while busy.
  - When the counter reaches TIMEOUT_CYCLES, the block aborts to IDLE exactly like clear and pulses timeout_err for one cycle, with no frame_valid.
- Undefined: no counter, and timeout_err is tied 0.

## Structure
- Package crc7_pkg contains:
  - CRC7_W=7;
  - CRC7_POLY=7'h09;
  - state enum {IDLE, PAYLOAD, CRC, END};
  - function crc7_next(c, bit).
- One sub-module, crc7_h45_accum: the 7-bit CRC register with seed, clear and step inputs. It is instantiated once; the FSM, counters and shift registers stay in the top.

## Test plan
- Reset: assert RST for 3 cycles mid-stream. Required: all outputs 0, busy=0, and no frame_valid after release.
- Feed 48'h400000000095 MSB first with enable every cycle. Required:
  - exactly one frame_valid;
  - frame_data=40'h4000000000, rx_crc=7'h4A;
  - crc_err=0, end_err=0.
- Feed 48'h48000001AA87 with enable on alternate cycles. Required:
  - frame_data=40'h48000001AA, rx_crc=7'h43;
  - no errors;
  - strobe arrives 1 cycle after the 48th enabled bit.
- Error cases:
  - 48'h400000000097 gives crc_err=1, end_err=0, rx_crc=7'h4B.
  - 48'h400000000094 gives crc_err=0, end_err=1.
- Abort and back-to-back:
  - After 20 bits of CMD0, pulse clear, then send two complete CMD0 frames back to back. Required: exactly two clean strobes, no spurious strobe from the aborted frame.
  - Same case with clear and enable coincident: the bit is dropped.
- With CRC7_CHK_TIMEOUT_EN and TIMEOUT_CYCLES=16, stop enable after 10 bits. Required: timeout_err pulse 16 cycles after the last enable, busy=0, no frame_valid; a following full frame checks clean.

Source files
------------

// File: rtl/crc7_pkg.sv
// Shared types and CRC7 (x^7+x^3+1) step function
// for the serial CRC7 frame checker.
package crc7_pkg;

  localparam int         CRC7_W    = 7;
  localparam logic [6:0] CRC7_POLY = 7'h09;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CRC,
    END
  } crc7_state_e;

  // One serial CRC step: feedback is the incoming bit
  // xored with the register MSB.
  function automatic logic [CRC7_W-1:0] crc7_next(
    input logic [CRC7_W-1:0] c,
    input logic              din
  );
    logic fb;
    fb = din ^ c[CRC7_W-1];
    return {c[CRC7_W-2:0], 1'b0} ^ (fb ? CRC7_POLY : '0);
  endfunction

endpackage

// File: rtl/crc7_h45_accum.sv
// CRC7 accumulator register: seed load, clear and
// single-bit step, seed and step may combine in one cycle.
module crc7_h45_accum
  import crc7_pkg::*;
#(
  parameter logic [CRC7_W-1:0] SEED = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              seed_i,
  input  logic              step_i,
  input  logic              bit_i,
  output logic [CRC7_W-1:0] crc_o
);

  logic [CRC7_W-1:0] crc_q;
  logic [CRC7_W-1:0] crc_d;
  logic [CRC7_W-1:0] base;

  // Next value: clear wins, else optional seed then optional step
  always_comb begin
    base  = seed_i ? SEED : crc_q;
    crc_d = step_i ? crc7_next(base, bit_i) : base;
    if (clear_i) crc_d = SEED;
  end

  // CRC register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) crc_q <= SEED;
    else       crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/crc7_h45_frame_checker.sv
// Serial CRC7 command-frame receiver/checker.
// Optional idle timeout: define CRC7_CHK_TIMEOUT_EN.
module crc7_h45_frame_checker
  import crc7_pkg::*;
#(
  parameter logic [6:0] RST_SEED_VAL   = 7'h00,
  parameter int         PAYLOAD_BITS   = 40,
  parameter int         TIMEOUT_CYCLES = 256
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    clear,
  input  logic                    enable,
  input  logic                    in,
  output logic                    busy,
  output logic                    frame_valid,
  output logic [PAYLOAD_BITS-1:0] frame_data,
  output logic [CRC7_W-1:0]       rx_crc,
  output logic                    crc_err,
  output logic                    end_err,
  output logic                    timeout_err
);

  if (PAYLOAD_BITS < 8 || PAYLOAD_BITS > 64 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("crc7_h45_frame_checker: bad parameters");
  end

  localparam logic [6:0] LAST_PAY = 7'(PAYLOAD_BITS - 1);
  localparam logic [6:0] LAST_CRC = 7'(CRC7_W - 1);

  crc7_state_e state_q, state_d;

  logic [6:0]              cnt_q, cnt_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic [CRC7_W-1:0]       rxs_q, rxs_d;
  logic [PAYLOAD_BITS-1:0] fdata_q, fdata_d;
  logic [CRC7_W-1:0]       rxcrc_q, rxcrc_d;
  logic                    cerr_q, cerr_d;
  logic                    eerr_q, eerr_d;
  logic                    fv_q, fv_d;

  logic              abort;
  logic              tmo_hit;
  logic              crc_seed;
  logic              crc_step;
  logic [CRC7_W-1:0] crc_c;

  assign busy  = (state_q != IDLE);
  assign abort = clear | tmo_hit;

  crc7_h45_accum #(
    .SEED (RST_SEED_VAL)
  ) u_accum (
    .clk_i   (CLK),
    .rst_i   (RST),
    .clear_i (abort),
    .seed_i  (crc_seed),
    .step_i  (crc_step),
    .bit_i   (in),
    .crc_o   (crc_c)
  );

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: hunt, payload, CRC field, end bit
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable && !in) state_d = PAYLOAD;
      PAYLOAD: if (enable && cnt_q == LAST_PAY) state_d = CRC;
      CRC:     if (enable && cnt_q == LAST_CRC) state_d = END;
      END:     if (enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Datapath/outputs: shift payload and CRC field, load result on end bit
  always_comb begin
    cnt_d    = cnt_q;
    data_d   = data_q;
    rxs_d    = rxs_q;
    fdata_d  = fdata_q;
    rxcrc_d  = rxcrc_q;
    cerr_d   = cerr_q;
    eerr_d   = eerr_q;
    fv_d     = 1'b0;
    crc_seed = 1'b0;
    crc_step = 1'b0;
    if (enable && !abort) begin
      unique case (state_q)
        IDLE: begin
          if (!in) begin
            crc_seed = 1'b1;
            crc_step = 1'b1;
            data_d   = {data_q[PAYLOAD_BITS-2:0], in};
            cnt_d    = 7'd1;
          end
        end
        PAYLOAD: begin
          crc_step = 1'b1;
          data_d   = {data_q[PAYLOAD_BITS-2:0], in};
          cnt_d    = (cnt_q == LAST_PAY) ? 7'd0 : cnt_q + 7'd1;
        end
        CRC: begin
          rxs_d = {rxs_q[CRC7_W-2:0], in};
          cnt_d = (cnt_q == LAST_CRC) ? 7'd0 : cnt_q + 7'd1;
        end
        END: begin
          fdata_d = data_q;
          rxcrc_d = rxs_q;
          cerr_d  = (rxs_q != crc_c);
          eerr_d  = !in;
          fv_d    = 1'b1;
        end
        default: ;
      endcase
    end
    if (abort) cnt_d = 7'd0;
  end

  // Working and held result registers; held ones survive clear
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q   <= '0;
      data_q  <= '0;
      rxs_q   <= '0;
      fdata_q <= '0;
      rxcrc_q <= '0;
      cerr_q  <= 1'b0;
      eerr_q  <= 1'b0;
      fv_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rxs_q   <= rxs_d;
      fdata_q <= fdata_d;
      rxcrc_q <= rxcrc_d;
      cerr_q  <= cerr_d;
      eerr_q  <= eerr_d;
      fv_q    <= fv_d;
    end
  end

  assign frame_valid = fv_q;
  assign frame_data  = fdata_q;
  assign rx_crc      = rxcrc_q;
  assign crc_err     = cerr_q;
  assign end_err     = eerr_q;

`ifdef CRC7_CHK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          to_q;

  assign tmo_hit = busy && !enable && (tmo_q == TO_LAST);

  // Idle counter: restarts on every bit, counts stalls while busy
  always_comb begin
    tmo_d = tmo_q + 1'b1;
    if (clear || enable || !busy || tmo_hit) tmo_d = '0;
  end

  // Idle counter and abort strobe registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tmo_q <= '0;
      to_q  <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      to_q  <= tmo_hit && !clear;
    end
  end

  assign timeout_err = to_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_crc7_h45_frame_checker.sv
// Scoreboard bench for crc7_h45_frame_checker.
// Expected results derive from frame bits and a long-division CRC model.
module tb_crc7_h45_frame_checker;

  localparam int PB = 40;
`ifdef CRC7_CHK_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 256;
`endif

  localparam logic [47:0] F_CMD0 = 48'h400000000095;
  localparam logic [47:0] F_CMD8 = 48'h48000001AA87;
  localparam logic [47:0] F_BADC = 48'h400000000097;
  localparam logic [47:0] F_BADE = 48'h400000000094;

  typedef struct packed {
    logic [PB-1:0] d;
    logic [6:0]    c;
    logic          ce;
    logic          ee;
  } exp_t;

  logic          clk = 1'b0;
  logic          RST;
  logic          clear;
  logic          enable;
  logic          in;
  logic          busy;
  logic          frame_valid;
  logic [PB-1:0] frame_data;
  logic [6:0]    rx_crc;
  logic          crc_err;
  logic          end_err;
  logic          timeout_err;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_push = 0;
  int   n_fv   = 0;
  bit   to_ok  = 1'b0;

  crc7_h45_frame_checker #(
    .RST_SEED_VAL   (7'h00),
    .PAYLOAD_BITS   (PB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK         (clk),
    .RST         (RST),
    .clear       (clear),
    .enable      (enable),
    .in          (in),
    .busy        (busy),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .rx_crc      (rx_crc),
    .crc_err     (crc_err),
    .end_err     (end_err),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Polynomial long division of payload*x^7 by x^7+x^3+1
  function automatic logic [6:0] ref_crc(input logic [PB-1:0] d);
    logic [PB+6:0] r;
    r = {d, 7'b0};
    for (int i = PB + 6; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic exp_t mk_exp(input logic [47:0] f);
    exp_t e;
    e.d  = f[47:8];
    e.c  = f[7:1];
    e.ee = ~f[0];
    e.ce = (f[7:1] != ref_crc(f[47:8]));
    return e;
  endfunction

  // Drive the first n bits of a frame MSB first, gap idle cycles between bits
  task automatic send_bits(input logic [47:0] f, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      if (i > 0)
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      enable = 1'b1;
      in     = f[47-i];
      @(posedge clk);
      #1;
      enable = 1'b0;
      in     = 1'b1;
      if (i == 0) chk("busy_start", busy, 1);
    end
  endtask

  task automatic send_frame(input logic [47:0] f, input int gap);
    sb.push_back(mk_exp(f));
    n_push++;
    send_bits(f, 48, gap);
    chk("strobe_lat", frame_valid, 1);
    chk("busy_end", busy, 0);
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    exp_t e;
    if (frame_valid) begin
      n_fv++;
      if (sb.size() == 0) begin
        chk("spurious_fv", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("frame_data", frame_data, e.d);
        chk("rx_crc", rx_crc, e.c);
        chk("crc_err", crc_err, e.ce);
        chk("end_err", end_err, e.ee);
      end
    end
    if (timeout_err && !to_ok) chk("spurious_to", 1, 0);
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fv"}, frame_valid, 0);
    chk({tag, "_data"}, frame_data, 0);
    chk({tag, "_crc"}, rx_crc, 0);
    chk({tag, "_cerr"}, crc_err, 0);
    chk({tag, "_eerr"}, end_err, 0);
    chk({tag, "_to"}, timeout_err, 0);
  endtask

  initial begin
    logic [PB-1:0] d;
    logic [6:0]    c;
    logic [47:0]   f;
    int            k;

    RST    = 1'b1;
    clear  = 1'b0;
    enable = 1'b0;
    in     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst0");
    RST = 1'b0;
    @(posedge clk);
    #1;

    send_frame(F_CMD0, 0);
    chk("cmd0_data", frame_data, 40'h4000000000);
    chk("cmd0_crc", rx_crc, 7'h4A);

    // Reset in the middle of a frame
    send_bits(F_CMD8, 20, 0);
    RST = 1'b1;
    #1;
    chk_zero("rst_mid");
    repeat (3) @(posedge clk);
    #1;
    RST = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);

    send_frame(F_CMD8, 1);
    chk("cmd8_data", frame_data, 40'h48000001AA);
    chk("cmd8_crc", rx_crc, 7'h43);

    send_frame(F_BADC, 0);
    chk("badc_cerr", crc_err, 1);
    chk("badc_crc", rx_crc, 7'h4B);
    send_frame(F_BADE, 2);
    chk("bade_eerr", end_err, 1);
    chk("bade_cerr", crc_err, 0);

    // Clear pulse mid-frame, then two frames back to back
    send_bits(F_CMD0, 20, 0);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_hold", end_err, 1);
    send_frame(F_CMD0, 0);
    send_frame(F_CMD0, 0);

    // Clear coincident with an enabled start-like bit: bit dropped
    send_bits(F_CMD0, 20, 0);
    clear  = 1'b1;
    enable = 1'b1;
    in     = 1'b0;
    @(posedge clk);
    #1;
    clear  = 1'b0;
    enable = 1'b0;
    in     = 1'b1;
    chk("clr_en_busy", busy, 0);
    send_frame(F_CMD0, 0);
    send_frame(F_CMD0, 0);

    // Random payloads, some with corrupted CRC or end bit
    for (int r = 0; r < 6; r++) begin
      d  = {2'b01, 38'($urandom()), 6'($urandom())} >> 6;
      d[PB-1] = 1'b0;
      d[PB-2] = 1'b1;
      c  = ref_crc(d);
      k  = $urandom_range(0, 2);
      if (k == 1) c = c ^ 7'(1 << $urandom_range(0, 6));
      f  = {d, c, (k == 2) ? 1'b0 : 1'b1};
      send_frame(f, $urandom_range(0, 2));
    end

    // Stall after 10 bits
    send_bits(F_CMD0, 10, 0);
`ifdef CRC7_CHK_TIMEOUT_EN
    to_ok = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk);
      #1;
      if (i == TO - 1) chk("to_early", timeout_err, 0);
      if (i == TO) begin
        chk("to_pulse", timeout_err, 1);
        chk("to_busy", busy, 0);
      end
      if (i == TO + 1) chk("to_width", timeout_err, 0);
    end
    to_ok = 1'b0;
`else
    repeat (300) @(posedge clk);
    #1;
    chk("stall_busy", busy, 1);
    chk("stall_to", timeout_err, 0);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
`endif
    send_frame(F_CMD0, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    chk("n_strobes", n_fv, n_push);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
